// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial word stream: transmitter state encoding
// and the default frame width used by both ends of the link.
package serial_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } tx_state_e;

   localparam int unsigned SERIAL_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/serial_word_tx.sv
// MSB-first word serializer with a one-entry holding buffer so the next word can
// be queued while the current one shifts out, giving bubble-free back-to-back frames.
module serial_word_tx
   import serial_pkg::*;
#(
   parameter int unsigned WIDTH    = SERIAL_WIDTH_DEFAULT,
   parameter int unsigned GAP      = 0,
   parameter logic        IDLE_BIT = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             number,
   output logic             frame,
   output logic             sof,
   output logic             eof
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

   localparam logic [CW-1:0] CNT_TOP  = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [GW-1:0] GAP_TOP  = (GAP > 0) ? GW'(int'(GAP) - 1) : GW'(0);
   localparam logic [GW-1:0] GAP_ZERO = GW'(0);
   localparam logic [GW-1:0] GAP_ONE  = GW'(1);

   tx_state_e        state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic [WIDTH-1:0] buf_q, buf_d;
   logic             buf_full_q, buf_full_d;
   logic             number_q, number_d;
   logic             frame_q, frame_d;
   logic             sof_q, sof_d;
   logic             eof_q, eof_d;

   logic             accept_s;
   logic             take_next_s;
   logic             park_s;

   assign in_ready = !buf_full_q;
   assign accept_s = in_valid && !buf_full_q;

   assign number = number_q;
   assign frame  = frame_q;
   assign sof    = sof_q;
   assign eof    = eof_q;

   // Next-state, shifter, buffer routing and output decode
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      gap_d       = gap_q;
      buf_d       = buf_q;
      buf_full_d  = buf_full_q;
      take_next_s = 1'b0;
      park_s      = accept_s;

      case (state_q)
         ST_IDLE: begin
            take_next_s = 1'b1;
         end
         ST_SHIFT: begin
            if (cnt_q != CNT_ZERO) begin
               shift_d = {shift_q[WIDTH-2:0], 1'b0};
               cnt_d   = cnt_q - CNT_ONE;
            end else if (GAP == 0) begin
               take_next_s = 1'b1;
            end else begin
               state_d = ST_GAP;
               gap_d   = GAP_TOP;
            end
         end
         ST_GAP: begin
            if (gap_q != GAP_ZERO) begin
               gap_d = gap_q - GAP_ONE;
            end else begin
               take_next_s = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A buffered word always goes first; a full buffer also means no accept can happen
      if (take_next_s) begin
         if (buf_full_q) begin
            shift_d    = buf_q;
            cnt_d      = CNT_TOP;
            state_d    = ST_SHIFT;
            buf_full_d = 1'b0;
         end else if (accept_s) begin
            shift_d = in_data;
            cnt_d   = CNT_TOP;
            state_d = ST_SHIFT;
            park_s  = 1'b0;
         end else begin
            state_d = ST_IDLE;
         end
      end else begin
         park_s = accept_s;
      end

      if (park_s) begin
         buf_d      = in_data;
         buf_full_d = 1'b1;
      end else begin
         buf_d = buf_q;
      end

      frame_d  = (state_d == ST_SHIFT);
      sof_d    = frame_d && (cnt_d == CNT_TOP);
      eof_d    = frame_d && (cnt_d == CNT_ZERO);
      number_d = frame_d ? shift_d[WIDTH-1] : IDLE_BIT;
   end

   // State, datapath and registered serial outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         cnt_q      <= CNT_ZERO;
         gap_q      <= GAP_ZERO;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         number_q   <= IDLE_BIT;
         frame_q    <= 1'b0;
         sof_q      <= 1'b0;
         eof_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         gap_q      <= gap_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         number_q   <= number_d;
         frame_q    <= frame_d;
         sof_q      <= sof_d;
         eof_q      <= eof_d;
      end
   end

endmodule

// File: doc/serial_word_tx.md
# serial_word_tx

Serializer that accepts parallel words over a valid/ready handshake and emits them MSB-first, one bit per clock, on a single-bit `number` line. It is the transmit end of the bit-serial stream consumed by the `alternate` checker. It replaces hand-written stimulus loops with a synthesizable source. A one-entry holding buffer allows back-to-back frames with zero idle cycles.

## Interface
- `WIDTH`, 32: bits per frame; must be ≥ 2.
- `GAP`, 0: idle cycles inserted between consecutive frames; 0 means back-to-back.
- `IDLE_BIT`, 1'b0: value driven on `number` when no frame bit is active.
- `clk` input, 1: single clock; all state updates on the rising edge.
- `rst_n` input, 1: reset, asynchronous and active-low.
- `in_valid` input, 1: `in_data` holds a word to send.
- `in_ready` output, 1: block can accept a word this cycle.
- `in_data` input, WIDTH: word to serialize, MSB transmitted first.
- `number` output, 1: serial bit out, registered.
- `frame` output, 1: high while `number` carries a data bit.
- `sof` output, 1: high on the MSB cycle of a frame.
- `eof` output, 1: high on the LSB cycle of a frame.

## Operation
- Handshake: a word is accepted on a rising edge where `in_valid && in_ready`. `in_data` is sampled only at that edge.
- `in_ready` is `!buf_full`. It is combinational from the buffer flag and does not depend on `in_valid`.
- States:
  - IDLE: shifter empty.
  - SHIFT: bit counter running WIDTH-1 down to 0.
  - GAP: gap counter running GAP-1 down to 0.
- Acceptance routing:
  - In IDLE with the buffer empty, the word loads directly into the shifter and the state goes to SHIFT.
  - Otherwise the word loads into the buffer.
- End of frame, at the edge that ends the `eof` cycle:
  - GAP=0 and buffer full: load the shifter from the buffer, clear the buffer, stay in SHIFT.
  - GAP=0, buffer empty, word accepted on this edge: load that word directly into the shifter and stay in SHIFT.
  - GAP=0 with neither: go to IDLE.
  - GAP>0: go to GAP. On gap expiry, load from the buffer (else any word accepted on that edge) into SHIFT, or go to IDLE.
- In SHIFT, `number` = shifter MSB. The shifter shifts left each cycle.
- `frame` = (state==SHIFT). `sof` = SHIFT with count==WIDTH-1. `eof` = SHIFT with count==0.
- `number` = IDLE_BIT whenever `frame` is low.
- Counter width is `$clog2(WIDTH)`. The count never wraps; it reloads to WIDTH-1 on every shifter load.
- Reset (asynchronous, any state):
  - state IDLE, buffer emptied (pending word discarded), shifter cleared.
  - `number`=IDLE_BIT, `frame`=0, `sof`=0, `eof`=0, `in_ready`=1.
  - A partially sent frame is abandoned with no `eof`.

## Timing
- Latency: a word accepted at edge k from IDLE drives its MSB during cycle k→k+1 and its LSB during cycle k+WIDTH-1→k+WIDTH.
- Throughput, GAP=0: one bit per cycle with no bubbles, provided the next word is offered by the `eof` edge.
- Throughput, GAP=g: exactly g cycles with `frame`=0 between frames.
- `in_ready` drops the cycle after a word lands in the buffer and rises the cycle after the buffer drains into the shifter.
- At most two words are held at once: one shifting, one buffered.
- `sof` and `eof` are single-cycle pulses. Their edges coincide with `frame` edges at the start and end of each frame respectively.

## Structure
- Shared package `serial_pkg`: state encoding enum (IDLE/SHIFT/GAP) and a default frame width constant of 32, reused by the `alternate` bench.
- No sub-module. Shifter, buffer and counters stay in one module of roughly 150 lines.

## Test plan
- Reset values: hold `rst_n`=0 → `number`=0, `frame`=0, `sof`=0, `eof`=0, `in_ready`=1. Release with `in_valid`=0 for 5 cycles → no change.
- Single word 32'h1ECC0000, WIDTH=32, GAP=0:
  - first bit cycle follows the accept edge.
  - bit sequence 0001_1110_1100_1100 followed by 16 zeros.
  - `sof` on bit 31, `eof` on bit 0.
  - then IDLE with `number`=IDLE_BIT.
- Back-to-back, GAP=0, words 32'h1ECC0000, 32'hE133FFFF, 32'h9C3E07F0 offered continuously:
  - 96 contiguous `frame` cycles, exactly three `sof` and three `eof` pulses.
  - `in_ready` low while the buffer is full.
  - Output matches the words MSB-first; loopback into `alternate` agrees with the bit-by-bit golden model.
- GAP=2, two words:
  - exactly 2 cycles of `frame`=0 and `number`=IDLE_BIT between `eof` and the next `sof`.
  - a second word offered during the first frame is buffered, not lost.
- Reset mid-frame: assert `rst_n`=0 at bit 17 with a word buffered → all outputs return to reset values immediately. After release, no residual bits are emitted and `in_ready`=1.
- Handshake hold: `in_valid` high with `in_ready` low for 10 cycles with changing `in_data` → only the value present at the accepting edge is transmitted.
